// File: rtl/sram_cache.sv
// Two-way set-associative write-back, write-allocate data cache. Line data lives in four
// external byte-lane SRAM banks; tags/valid/dirty/LRU are held in flops here.
module sram_cache (
  input  logic        clk,
  input  logic        rst,
  input  logic        ren,
  input  logic        wen,
  input  logic [31:0] addr,
  input  logic [31:0] din,
  input  logic [4:0]  loadcntrl,
  input  logic [2:0]  storecntrl,
  output logic [31:0] dout,
  output logic        cache_rdy,
  output logic        mem_ren,
  output logic        mem_wen,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_din,
  input  logic [31:0] mem_dout,
  output logic [9:0]  cell_0_addr,
  output logic [7:0]  cell_0_din,
  output logic        cell_0_sense_en,
  output logic        cell_0_wen,
  input  logic [7:0]  cell_0_dout,
  output logic [9:0]  cell_1_addr,
  output logic [7:0]  cell_1_din,
  output logic        cell_1_sense_en,
  output logic        cell_1_wen,
  input  logic [7:0]  cell_1_dout,
  output logic [9:0]  cell_2_addr,
  output logic [7:0]  cell_2_din,
  output logic        cell_2_sense_en,
  output logic        cell_2_wen,
  input  logic [7:0]  cell_2_dout,
  output logic [9:0]  cell_3_addr,
  output logic [7:0]  cell_3_din,
  output logic        cell_3_sense_en,
  output logic        cell_3_wen,
  input  logic [7:0]  cell_3_dout
);

  typedef enum logic [2:0] {
    IDLE, LOOKUP, RESPOND, SRAM_TO_BUF, BUF_TO_MEM, MEM_TO_BUF, BUF_TO_SRAM
  } state_t;

  state_t      state, state_nxt;
  logic [5:0]  cnt;
  logic [5:0]  cap_idx;
  logic        req_store;
  logic [31:0] req_addr, req_din;
  logic [4:0]  req_lc;
  logic [2:0]  req_sc;
  logic [20:0] tag_q [16][2];
  logic [1:0]  valid_q [16];
  logic [1:0]  dirty_q [16];
  logic [15:0] lru_q;
  logic        victim_q;
  logic [20:0] victim_tag_q;
  logic [31:0] line_buf [32];

  logic [20:0] req_tag;
  logic [3:0]  req_idx;
  logic [4:0]  req_word;
  logic        hit0, hit1, hit, hit_way, victim_sel, victim_dirty;
  logic [31:0] bank_word, st_word;
  logic [3:0]  st_mask;

  logic [3:0][9:0] cell_addr_c;
  logic [3:0][7:0] cell_din_c;
  logic [3:0]      cell_se_c, cell_we_c;

  function automatic logic [31:0] fmt_load(input logic [31:0] w, input logic [1:0] ofs,
                                           input logic [4:0] lc);
    logic [31:0]        sh;
    logic signed [7:0]  b;
    logic signed [15:0] h;
    sh = w >> {ofs, 3'b000};
    b  = sh[7:0];
    h  = ofs[1] ? w[31:16] : w[15:0];
    case (lc)
      5'b00001: fmt_load = 32'(b);
      5'b00010: fmt_load = 32'(h);
      5'b01000: fmt_load = {24'b0, sh[7:0]};
      5'b10000: fmt_load = {16'b0, h[15:0]};
      default:  fmt_load = w;
    endcase
  endfunction

  function automatic logic [3:0] st_lanes(input logic [1:0] ofs, input logic [2:0] sc);
    case (sc)
      3'b001:  st_lanes = 4'b0001 << ofs;
      3'b010:  st_lanes = ofs[1] ? 4'b1100 : 4'b0011;
      default: st_lanes = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] st_data(input logic [31:0] d, input logic [2:0] sc);
    case (sc)
      3'b001:  st_data = {4{d[7:0]}};
      3'b010:  st_data = {2{d[15:0]}};
      default: st_data = d;
    endcase
  endfunction

  assign req_tag  = req_addr[31:11];
  assign req_idx  = req_addr[10:7];
  assign req_word = req_addr[6:2];
  assign hit0     = valid_q[req_idx][0] && (tag_q[req_idx][0] == req_tag);
  assign hit1     = valid_q[req_idx][1] && (tag_q[req_idx][1] == req_tag);
  assign hit      = hit0 | hit1;
  assign hit_way  = hit1;
  // Fill an invalid way first (way 0 preferred), otherwise replace the LRU way.
  assign victim_sel   = !valid_q[req_idx][0] ? 1'b0 :
                        !valid_q[req_idx][1] ? 1'b1 : lru_q[req_idx];
  assign victim_dirty = valid_q[req_idx][victim_sel] & dirty_q[req_idx][victim_sel];
  assign bank_word    = {cell_3_dout, cell_2_dout, cell_1_dout, cell_0_dout};
  assign st_word      = st_data(req_din, req_sc);
  assign st_mask      = st_lanes(req_addr[1:0], req_sc);
  assign cap_idx      = cnt - 6'd1;

  always_comb begin
    state_nxt   = state;
    cache_rdy   = 1'b0;
    mem_ren     = 1'b0;
    mem_wen     = 1'b0;
    mem_addr    = '0;
    mem_din     = '0;
    cell_addr_c = '0;
    cell_din_c  = '0;
    cell_se_c   = '0;
    cell_we_c   = '0;
    case (state)
      IDLE: begin
        cache_rdy = 1'b1;
        if (ren || wen) state_nxt = LOOKUP;
      end
      LOOKUP: begin
        if (hit) begin
          for (int k = 0; k < 4; k++) begin
            cell_addr_c[k] = {hit_way, req_idx, req_word};
            cell_din_c[k]  = st_word[8*k +: 8];
          end
          if (req_store) cell_we_c = st_mask;
          else           cell_se_c = 4'hf;
          state_nxt = RESPOND;
        end else begin
          state_nxt = victim_dirty ? SRAM_TO_BUF : MEM_TO_BUF;
        end
      end
      RESPOND: state_nxt = IDLE;
      SRAM_TO_BUF: begin
        if (cnt < 6'd32) begin
          cell_se_c = 4'hf;
          for (int k = 0; k < 4; k++) cell_addr_c[k] = {victim_q, req_idx, cnt[4:0]};
        end else begin
          state_nxt = BUF_TO_MEM;
        end
      end
      BUF_TO_MEM: begin
        mem_wen  = 1'b1;
        mem_addr = {victim_tag_q, req_idx, cnt[4:0], 2'b00};
        mem_din  = line_buf[cnt[4:0]];
        if (cnt == 6'd31) state_nxt = MEM_TO_BUF;
      end
      MEM_TO_BUF: begin
        if (cnt < 6'd32) begin
          mem_ren  = 1'b1;
          mem_addr = {req_tag, req_idx, cnt[4:0], 2'b00};
        end else begin
          state_nxt = BUF_TO_SRAM;
        end
      end
      BUF_TO_SRAM: begin
        cell_we_c = 4'hf;
        for (int k = 0; k < 4; k++) begin
          cell_addr_c[k] = {victim_q, req_idx, cnt[4:0]};
          cell_din_c[k]  = line_buf[cnt[4:0]][8*k +: 8];
        end
        if (cnt == 6'd31) state_nxt = LOOKUP;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Control state: FSM, phase counter, cache metadata, load result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      req_store <= 1'b0;
      lru_q     <= '0;
      dout      <= '0;
      victim_q  <= 1'b0;
      for (int s = 0; s < 16; s++) begin
        valid_q[s]  <= '0;
        dirty_q[s]  <= '0;
        tag_q[s][0] <= '0;
        tag_q[s][1] <= '0;
      end
    end else begin
      state <= state_nxt;
      cnt   <= (state_nxt != state) ? 6'd0 : cnt + 6'd1;
      if (state == IDLE && (ren || wen)) req_store <= wen;
      if (state == LOOKUP) begin
        if (hit) begin
          lru_q[req_idx] <= ~hit_way;
          if (req_store) dirty_q[req_idx][hit_way] <= 1'b1;
        end else begin
          victim_q <= victim_sel;
        end
      end
      if (state == BUF_TO_SRAM && cnt == 6'd31) begin
        tag_q[req_idx][victim_q]   <= req_tag;
        valid_q[req_idx][victim_q] <= 1'b1;
        dirty_q[req_idx][victim_q] <= 1'b0;
      end
      if (state == RESPOND && !req_store) dout <= fmt_load(bank_word, req_addr[1:0], req_lc);
    end
  end

  // Datapath registers: request copy and line buffer.
  always_ff @(posedge clk) begin
    if (state == IDLE && (ren || wen)) begin
      req_addr <= addr;
      req_din  <= din;
      req_lc   <= $onehot(loadcntrl) ? loadcntrl : 5'b00100;
      req_sc   <= $onehot(storecntrl) ? storecntrl : 3'b100;
    end
    if (state == LOOKUP && !hit) victim_tag_q <= tag_q[req_idx][victim_sel];
    if (state == SRAM_TO_BUF && cnt != 6'd0) line_buf[cap_idx[4:0]] <= bank_word;
    if (state == MEM_TO_BUF && cnt != 6'd0)  line_buf[cap_idx[4:0]] <= mem_dout;
  end

  assign cell_0_addr = cell_addr_c[0];
  assign cell_1_addr = cell_addr_c[1];
  assign cell_2_addr = cell_addr_c[2];
  assign cell_3_addr = cell_addr_c[3];
  assign cell_0_din  = cell_din_c[0];
  assign cell_1_din  = cell_din_c[1];
  assign cell_2_din  = cell_din_c[2];
  assign cell_3_din  = cell_din_c[3];
  assign cell_0_sense_en = cell_se_c[0];
  assign cell_1_sense_en = cell_se_c[1];
  assign cell_2_sense_en = cell_se_c[2];
  assign cell_3_sense_en = cell_se_c[3];
  assign cell_0_wen = cell_we_c[0];
  assign cell_1_wen = cell_we_c[1];
  assign cell_2_wen = cell_we_c[2];
  assign cell_3_wen = cell_we_c[3];

endmodule

// File: tb/tb_sram_cache.sv
// Bench for sram_cache: byte-bank SRAM and word memory models, directed scenarios and
// randomized loads/stores checked against a flat-memory plus cache-occupancy reference.
module tb_sram_cache;
  logic        clk, rst;
  logic        ren, wen;
  logic [31:0] addr, din, dout;
  logic [4:0]  loadcntrl;
  logic [2:0]  storecntrl;
  logic        cache_rdy, mem_ren, mem_wen;
  logic [31:0] mem_addr, mem_din, mem_dout;
  logic [9:0]  c_addr [4];
  logic [7:0]  c_din [4];
  logic [7:0]  s_dout [4];
  logic        c_se [4];
  logic        c_we [4];

  logic [7:0]  sram [4][1024];
  logic [31:0] mem [65536];
  int          n_memw = 0, n_memr = 0;
  int          n_checks = 0, n_fail = 0;

  logic [31:0] ref_mem [65536];
  logic [20:0] m_tag [16][2];
  logic        m_valid [16][2];
  logic        m_dirty [16][2];
  logic        m_lru [16];
  logic [31:0] exp_dout;

  sram_cache dut (
    .clk(clk), .rst(rst), .ren(ren), .wen(wen), .addr(addr), .din(din),
    .loadcntrl(loadcntrl), .storecntrl(storecntrl), .dout(dout), .cache_rdy(cache_rdy),
    .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_dout(mem_dout),
    .cell_0_addr(c_addr[0]), .cell_0_din(c_din[0]), .cell_0_sense_en(c_se[0]),
    .cell_0_wen(c_we[0]), .cell_0_dout(s_dout[0]),
    .cell_1_addr(c_addr[1]), .cell_1_din(c_din[1]), .cell_1_sense_en(c_se[1]),
    .cell_1_wen(c_we[1]), .cell_1_dout(s_dout[1]),
    .cell_2_addr(c_addr[2]), .cell_2_din(c_din[2]), .cell_2_sense_en(c_se[2]),
    .cell_2_wen(c_we[2]), .cell_2_dout(s_dout[2]),
    .cell_3_addr(c_addr[3]), .cell_3_din(c_din[3]), .cell_3_sense_en(c_se[3]),
    .cell_3_wen(c_we[3]), .cell_3_dout(s_dout[3])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (rst) begin
        for (int i = 0; i < 1024; i++) sram[k][i] <= 8'h00;
        s_dout[k] <= 8'h00;
      end else begin
        if (c_we[k]) sram[k][c_addr[k]] <= c_din[k];
        if (c_se[k]) s_dout[k] <= sram[k][c_addr[k]];
      end
    end
  end

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 65536; i++) mem[i] <= 32'(i) << 2;
      mem_dout <= '0;
    end else begin
      if (mem_wen) mem[mem_addr[17:2]] <= mem_din;
      if (mem_ren) mem_dout <= mem[mem_addr[17:2]];
    end
  end

  always @(posedge clk) begin
    if (mem_wen) n_memw <= n_memw + 1;
    if (mem_ren) n_memr <= n_memr + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic ref_reset();
    for (int i = 0; i < 65536; i++) ref_mem[i] = 32'(i) << 2;
    for (int s = 0; s < 16; s++) begin
      m_lru[s] = 1'b0;
      for (int w = 0; w < 2; w++) begin
        m_tag[s][w] = '0; m_valid[s][w] = 1'b0; m_dirty[s][w] = 1'b0;
      end
    end
    exp_dout = '0;
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, ".rdy"}, {31'b0, cache_rdy}, 32'd1);
    chk({tag, ".dout"}, dout, 32'd0);
    chk({tag, ".mem_strb"}, {30'b0, mem_ren, mem_wen}, 32'd0);
    chk({tag, ".mem_addr"}, mem_addr, 32'd0);
    chk({tag, ".mem_din"}, mem_din, 32'd0);
    chk({tag, ".cell_strb"}, {24'b0, c_se[0], c_se[1], c_se[2], c_se[3],
                              c_we[0], c_we[1], c_we[2], c_we[3]}, 32'd0);
    chk({tag, ".cell_addr"}, {2'b0, c_addr[0], c_addr[1], c_addr[2]}, 32'd0);
    chk({tag, ".cell_din"}, {c_din[0], c_din[1], c_din[2], c_din[3]}, 32'd0);
  endtask

  // One request: predicts latency/traffic/data from the reference, then drives the DUT.
  task automatic run_op(input string tag, input bit do_ld, input bit do_st,
                        input logic [31:0] a, input logic [31:0] d,
                        input logic [4:0] lc, input logic [2:0] sc);
    logic [3:0]  set;
    logic [20:0] t;
    logic [15:0] wi;
    logic [31:0] w, v;
    bit          hit, way, dev;
    int          exp_lat, exp_w, exp_r, cyc, w0, r0;
    set = a[10:7]; t = a[31:11]; wi = a[17:2];
    hit = 1'b0; way = 1'b0;
    for (int k = 0; k < 2; k++)
      if (m_valid[set][k] && m_tag[set][k] == t) begin hit = 1'b1; way = k[0]; end
    if (hit) begin
      exp_lat = 2; exp_w = 0; exp_r = 0;
    end else begin
      way = !m_valid[set][0] ? 1'b0 : !m_valid[set][1] ? 1'b1 : m_lru[set];
      dev = m_valid[set][way] && m_dirty[set][way];
      exp_lat = dev ? 133 : 68; exp_w = dev ? 32 : 0; exp_r = 32;
      m_tag[set][way] = t; m_valid[set][way] = 1'b1; m_dirty[set][way] = 1'b0;
    end
    m_lru[set] = ~way;
    w = ref_mem[wi];
    if (do_st) begin
      m_dirty[set][way] = 1'b1;
      if (sc == 3'b001)      w[8*a[1:0] +: 8] = d[7:0];
      else if (sc == 3'b010) w[16*a[1] +: 16] = d[15:0];
      else                   w = d;
      ref_mem[wi] = w;
    end else begin
      v = w >> (8 * a[1:0]);
      if ($countones(lc) != 1 || lc == 5'b00100) exp_dout = w;
      else if (lc == 5'b00001) exp_dout = {{24{v[7]}}, v[7:0]};
      else if (lc == 5'b01000) exp_dout = {24'b0, v[7:0]};
      else if (lc == 5'b00010) exp_dout = a[1] ? {{16{w[31]}}, w[31:16]} : {{16{w[15]}}, w[15:0]};
      else                     exp_dout = a[1] ? {16'b0, w[31:16]} : {16'b0, w[15:0]};
    end

    @(negedge clk);
    ren = do_ld; wen = do_st; addr = a; din = d; loadcntrl = lc; storecntrl = sc;
    w0 = n_memw; r0 = n_memr;
    @(posedge clk); #1;
    ren = 1'b0; wen = 1'b0; addr = $urandom; din = $urandom;
    cyc = 0;
    while (!cache_rdy && cyc < 300) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk({tag, ".lat"}, 32'(cyc), 32'(exp_lat));
    chk({tag, ".dout"}, dout, exp_dout);
    chk({tag, ".memw"}, 32'(n_memw - w0), 32'(exp_w));
    chk({tag, ".memr"}, 32'(n_memr - r0), 32'(exp_r));
  endtask

  initial begin
    logic [31:0] a;
    int          op;
    logic [4:0]  lc;
    logic [2:0]  sc;
    rst = 1'b1; ren = 1'b0; wen = 1'b0; addr = '0; din = '0;
    loadcntrl = '0; storecntrl = '0;
    ref_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_idle_outputs("reset");
    @(negedge clk) rst = 1'b0;

    run_op("lw0_cold", 1, 0, 32'h0000_0000, 0, 5'b00100, 3'b000);
    run_op("lw4_hit",  1, 0, 32'h0000_0004, 0, 5'b00100, 3'b000);
    run_op("lw8_hit",  1, 0, 32'h0000_0008, 0, 5'b00100, 3'b000);
    run_op("sw_miss",  0, 1, 32'hace1_2000, 32'hdead_beef, 5'b00000, 3'b100);
    run_op("lw_st",    1, 0, 32'hace1_2000, 0, 5'b00100, 3'b000);
    run_op("lw_nbr",   1, 0, 32'hace1_2004, 0, 5'b00100, 3'b000);
    run_op("lb",       1, 0, 32'hace1_2003, 0, 5'b00001, 3'b000);
    run_op("lbu",      1, 0, 32'hace1_2003, 0, 5'b01000, 3'b000);
    run_op("lh",       1, 0, 32'hace1_2002, 0, 5'b00010, 3'b000);
    run_op("lhu",      1, 0, 32'hace1_2000, 0, 5'b10000, 3'b000);
    run_op("lw0_mru",  1, 0, 32'h0000_0000, 0, 5'b00100, 3'b000);
    run_op("dirty_ev", 1, 0, 32'hbeef_2000, 0, 5'b00100, 3'b000);
    chk("wb_word", mem[16'h4800], 32'hdead_beef);
    run_op("clean_ev", 1, 0, 32'hace1_2000, 0, 5'b00100, 3'b000);
    chk("clean_ev.val", dout, 32'hdead_beef);
    run_op("sh_hit",   0, 1, 32'hace1_2006, 32'h1234_5678, 5'b00000, 3'b010);
    run_op("sb_both",  1, 1, 32'hace1_2005, 32'h0000_00a5, 5'b00100, 3'b001);
    run_op("lw_chk",   1, 0, 32'hace1_2004, 0, 5'b00000, 3'b000);

    // Abort a clean fill part-way through and confirm the cache comes back cold.
    @(negedge clk);
    ren = 1'b1; addr = 32'h0000_1000; loadcntrl = 5'b00100;
    @(posedge clk); #1;
    ren = 1'b0;
    repeat (12) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    chk_idle_outputs("midrst");
    @(negedge clk) rst = 1'b0;
    ref_reset();
    run_op("post_rst", 1, 0, 32'h0000_0000, 0, 5'b00100, 3'b000);

    for (int i = 0; i < 60; i++) begin
      a  = (32'($urandom_range(0, 3)) << 11) | (32'($urandom_range(0, 3)) << 7) |
           (32'($urandom_range(0, 31)) << 2) | 32'($urandom_range(0, 3));
      op = $urandom_range(0, 3);
      lc = 5'b00001 << $urandom_range(0, 4);
      if ($urandom_range(0, 7) == 0) lc = 5'b00000;
      sc = 3'b001 << $urandom_range(0, 2);
      run_op("rnd", op != 2, op >= 2, a, $urandom, lc, sc);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
